// File: rtl/dac_pacer_pkg.sv
// Shared definitions for the DAC stream pacer.
// Contents: register address map, CTRL/STATUS bit indices, the 16-bit
// statistics counter type and a saturating increment helper.
package dac_pacer_pkg;

  localparam logic [2:0] ADR_CTRL     = 3'd0;
  localparam logic [2:0] ADR_RATE     = 3'd1;
  localparam logic [2:0] ADR_STATUS   = 3'd2;
  localparam logic [2:0] ADR_UNDERRUN = 3'd3;
  localparam logic [2:0] ADR_LATE     = 3'd4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CLR     = 1;
  localparam int STATUS_EMPTY = 14;
  localparam int STATUS_FULL  = 15;

  typedef logic [15:0] cnt16_t;

  // Statistics counters stick at all-ones rather than wrapping.
  function automatic cnt16_t sat_inc(input cnt16_t v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dac_stream_pacer_if.sv
// Bus bundle of the DAC stream pacer: Avalon-MM register port, Avalon-ST
// pair sink from the producer, and the two Avalon-ST sample sources toward
// the DAC driver.
// Modports:
//   slave  - pacer side (register slave, stream sink, stream sources)
//   master - environment side (register master, producer, DAC driver)
interface dac_stream_pacer_if #(
  parameter int DATA_WIDTH = 14
);
  logic [2:0]              avsAdr;
  logic                    avsWr;
  logic [15:0]             avsWrData;
  logic                    avsRd;
  logic [15:0]             avsRdData;
  logic                    snkValid;
  logic [2*DATA_WIDTH-1:0] snkData;
  logic                    snkRdy;
  logic                    srcValid0;
  logic [DATA_WIDTH-1:0]   srcData0;
  logic                    srcRdy0;
  logic                    srcValid1;
  logic [DATA_WIDTH-1:0]   srcData1;
  logic                    srcRdy1;

  modport slave (
    input  avsAdr, avsWr, avsWrData, avsRd,
    output avsRdData,
    input  snkValid, snkData,
    output snkRdy,
    output srcValid0, srcData0,
    input  srcRdy0,
    output srcValid1, srcData1,
    input  srcRdy1
  );

  modport master (
    output avsAdr, avsWr, avsWrData, avsRd,
    input  avsRdData,
    output snkValid, snkData,
    input  snkRdy,
    input  srcValid0, srcData0,
    output srcRdy0,
    input  srcValid1, srcData1,
    output srcRdy1
  );
endinterface

// File: rtl/dac_pacer_fifo.sv
// Synchronous show-ahead FIFO holding sample pairs for the DAC pacer.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   push, din    write request and data (ignored while full)
//   pop          read request (ignored while empty)
//   dout         head entry, valid whenever !empty
//   level        number of stored entries (0 .. 2**AW)
//   empty, full  derived from the registered level
module dac_pacer_fifo #(
  parameter int WIDTH = 28,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      level,
  output logic             empty,
  output logic             full
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  // A pop in the same cycle does not free a slot for a push when full.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dac_stream_pacer.sv
// DAC stream pacer: buffers {ch1,ch0} sample pairs from a bursty producer
// and releases one pair per programmable sample period (RATE+1 clocks) to
// the two DAC driver channels.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    dac_stream_pacer_if.slave (register port, pair sink, ch0/ch1 sources)
// Registers: 0 CTRL (b0 EN, b1 CLR write-1 pulse), 1 RATE, 2 STATUS
//   (level, b14 empty, b15 full), 3 UNDERRUN, 4 LATE; others read 0.
// Build option: define DAC_PACER_HOLD_LAST_EN to re-present the last popped
//   pair when a tick finds the FIFO empty (UNDERRUN still counts).
module dac_stream_pacer
  import dac_pacer_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int FIFO_AW    = 6,
  parameter int RATE_RST   = 99
) (
  input  logic                clk,
  input  logic                reset,
  dac_stream_pacer_if.slave   bus
);

  logic                    en;
  cnt16_t                  rate;
  cnt16_t                  rate_cnt;
  cnt16_t                  underrun;
  cnt16_t                  late;
  logic [15:0]             rd_data;
  logic [15:0]             rd_mux;

  logic                    wr_ctrl;
  logic                    wr_rate;
  logic                    clr;
  logic                    tick;
  logic                    src_busy;
  logic                    late_inc;
  logic                    under_inc;
  logic                    pop;

  logic                    fifo_push;
  logic [2*DATA_WIDTH-1:0] fifo_dout;
  logic [FIFO_AW:0]        fifo_level;
  logic                    fifo_empty;
  logic                    fifo_full;

  logic                    valid0;
  logic                    valid1;
  logic [DATA_WIDTH-1:0]   data0;
  logic [DATA_WIDTH-1:0]   data1;

  dac_pacer_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (pop),
    .din   (bus.snkData),
    .dout  (fifo_dout),
    .level (fifo_level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign fifo_push  = bus.snkValid && !fifo_full;
  assign bus.snkRdy = !fifo_full;

  assign wr_ctrl = bus.avsWr && (bus.avsAdr == ADR_CTRL);
  assign wr_rate = bus.avsWr && (bus.avsAdr == ADR_RATE);
  assign clr     = wr_ctrl && bus.avsWrData[CTRL_CLR];

  // Tick arbitration: a pair still in flight on either channel wins over
  // popping, so a slow driver shows up as LATE instead of dropped samples.
  assign tick      = en && (rate_cnt == rate);
  assign src_busy  = valid0 || valid1;
  assign late_inc  = tick && src_busy;
  assign under_inc = tick && !src_busy && fifo_empty;
  assign pop       = tick && !src_busy && !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      rate_cnt <= '0;
    end else if (!en || wr_rate || (rate_cnt == rate)) begin
      rate_cnt <= '0;
    end else begin
      rate_cnt <= rate_cnt + 16'd1;
    end
  end

  // Data registers double as the "last popped pair" for the hold option.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      data0  <= '0;
      data1  <= '0;
    end else if (pop) begin
      valid0 <= 1'b1;
      valid1 <= 1'b1;
      data0  <= fifo_dout[DATA_WIDTH-1:0];
      data1  <= fifo_dout[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef DAC_PACER_HOLD_LAST_EN
    end else if (under_inc) begin
      valid0 <= 1'b1;
      valid1 <= 1'b1;
`endif
    end else begin
      if (valid0 && bus.srcRdy0) valid0 <= 1'b0;
      if (valid1 && bus.srcRdy1) valid1 <= 1'b0;
    end
  end

  assign bus.srcValid0 = valid0;
  assign bus.srcValid1 = valid1;
  assign bus.srcData0  = data0;
  assign bus.srcData1  = data1;

  always_comb begin
    rd_mux = '0;
    case (bus.avsAdr)
      ADR_CTRL:     rd_mux[CTRL_EN] = en;
      ADR_RATE:     rd_mux = rate;
      ADR_STATUS: begin
        rd_mux[FIFO_AW:0]   = fifo_level;
        rd_mux[STATUS_EMPTY] = fifo_empty;
        rd_mux[STATUS_FULL]  = fifo_full;
      end
      ADR_UNDERRUN: rd_mux = underrun;
      ADR_LATE:     rd_mux = late;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en       <= 1'b0;
      rate     <= 16'(RATE_RST);
      underrun <= '0;
      late     <= '0;
      rd_data  <= '0;
    end else begin
      if (wr_ctrl) en   <= bus.avsWrData[CTRL_EN];
      if (wr_rate) rate <= bus.avsWrData;
      // Clear dominates a coincident increment.
      if (clr) begin
        underrun <= '0;
        late     <= '0;
      end else begin
        if (under_inc) underrun <= sat_inc(underrun);
        if (late_inc)  late     <= sat_inc(late);
      end
      if (bus.avsRd) rd_data <= rd_mux;
    end
  end

  assign bus.avsRdData = rd_data;

endmodule

// File: tb/tb_dac_stream_pacer.sv
module tb_dac_stream_pacer;
  localparam int DW       = 14;
  localparam int AW       = 6;
  localparam int RATE_RST = 99;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dac_stream_pacer_if #(.DATA_WIDTH(DW)) bus();

  dac_stream_pacer #(
    .DATA_WIDTH (DW),
    .FIFO_AW    (AW),
    .RATE_RST   (RATE_RST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total   = 0;
  int bad     = 0;
  int cyc_cnt = 0;
  int n0      = 0;
  int n1      = 0;
  int w;
  int n0_base;

  logic [DW-1:0] exp0_q[$];
  logic [DW-1:0] exp1_q[$];
  logic [15:0]   rd_q[$];
  string         rd_name_q[$];
  int            t0_q[$];
  logic          rd_pend = 1'b0;
  logic [DW-1:0] e0;
  logic [DW-1:0] e1;
  logic [15:0]   er;
  string         en_name;
  logic [DW-1:0] c0;
  logic [DW-1:0] c1;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc_cnt < c) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.avsAdr    = a;
    bus.avsWrData = d;
    bus.avsWr     = 1'b1;
    step();
    bus.avsWr     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string nm);
    rd_q.push_back(e);
    rd_name_q.push_back(nm);
    bus.avsAdr = a;
    bus.avsRd  = 1'b1;
    step();
    bus.avsRd  = 1'b0;
  endtask

  task automatic push_pair(input logic [DW-1:0] ch1, input logic [DW-1:0] ch0, input bit expect_out);
    bus.snkData  = {ch1, ch0};
    bus.snkValid = 1'b1;
    step();
    bus.snkValid = 1'b0;
    if (expect_out) begin
      exp0_q.push_back(ch0);
      exp1_q.push_back(ch1);
    end
  endtask

  // Monitor: stream transfers and register read data against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.srcValid0 && bus.srcRdy0) begin
        n0++;
        t0_q.push_back(cyc_cnt);
        if (exp0_q.size() == 0) chk("ch0_unexpected", {18'd0, bus.srcData0}, 32'hFFFF_FFFF);
        else begin
          e0 = exp0_q.pop_front();
          chk("ch0_data", {18'd0, bus.srcData0}, {18'd0, e0});
        end
      end
      if (bus.srcValid1 && bus.srcRdy1) begin
        n1++;
        if (exp1_q.size() == 0) chk("ch1_unexpected", {18'd0, bus.srcData1}, 32'hFFFF_FFFF);
        else begin
          e1 = exp1_q.pop_front();
          chk("ch1_data", {18'd0, bus.srcData1}, {18'd0, e1});
        end
      end
    end
    if (rd_pend) begin
      if (rd_q.size() == 0) chk("rd_unexpected", {16'd0, bus.avsRdData}, 32'hFFFF_FFFF);
      else begin
        er      = rd_q.pop_front();
        en_name = rd_name_q.pop_front();
        chk(en_name, {16'd0, bus.avsRdData}, {16'd0, er});
      end
    end
    rd_pend = bus.avsRd;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.avsAdr    = '0;
    bus.avsWr     = 1'b0;
    bus.avsWrData = '0;
    bus.avsRd     = 1'b0;
    bus.snkValid  = 1'b0;
    bus.snkData   = '0;
    bus.srcRdy0   = 1'b1;
    bus.srcRdy1   = 1'b1;
    reset         = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    chk("rst_snkRdy",    {31'd0, bus.snkRdy},    32'd1);
    chk("rst_srcValid0", {31'd0, bus.srcValid0}, 32'd0);
    chk("rst_srcValid1", {31'd0, bus.srcValid1}, 32'd0);
    chk("rst_srcData0",  {18'd0, bus.srcData0},  32'd0);
    chk("rst_rddata",    {16'd0, bus.avsRdData}, 32'd0);
    rd(3'd0, 16'h0000, "rst_ctrl");
    rd(3'd1, 16'(RATE_RST), "rst_rate");
    rd(3'd2, 16'h4000, "rst_status");
    rd(3'd3, 16'h0000, "rst_underrun");
    rd(3'd4, 16'h0000, "rst_late");
    rd(3'd6, 16'h0000, "adr6_zero");

`ifndef DAC_PACER_HOLD_LAST_EN
    // Four pairs at RATE=3: one release every 4 cycles, then an underrun.
    wr(3'd1, 16'd3);
    push_pair(14'h0011, 14'h0010, 1'b1);
    push_pair(14'h0021, 14'h0020, 1'b1);
    push_pair(14'h0031, 14'h0030, 1'b1);
    push_pair(14'h0041, 14'h0040, 1'b1);
    rd(3'd2, 16'h0004, "t1_level4");
    t0_q.delete();
    w = cyc_cnt;
    wr(3'd0, 16'h0001);
    wait_until(w + 21);
    wr(3'd0, 16'h0000);
    rd(3'd3, 16'h0001, "t1_underrun");
    rd(3'd4, 16'h0000, "t1_late");
    rd(3'd2, 16'h4000, "t1_status_empty");
    chk("t1_xfer_count", t0_q.size(), 32'd4);
    if (t0_q.size() == 4) begin
      chk("t1_first_valid_cycle", t0_q[0], w + 5);
      for (int i = 1; i < 4; i++) chk("t1_period", t0_q[i] - t0_q[i-1], 32'd4);
    end

    // Fill to capacity: snkRdy drops, extra pair is ignored.
    for (int i = 0; i < (1 << AW); i++) begin
      c0 = 14'(i * 3 + 1);
      c1 = 14'(16'h3000 + i);
      push_pair(c1, c0, 1'b1);
    end
    chk("t2_snkRdy_full", {31'd0, bus.snkRdy}, 32'd0);
    rd(3'd2, 16'h8040, "t2_status_full");
    push_pair(14'h3FFF, 14'h3FFF, 1'b0);
    rd(3'd2, 16'h8040, "t2_status_after_extra");
    wr(3'd1, 16'd1);
    w = cyc_cnt;
    wr(3'd0, 16'h0001);
    wait_until(w + 140);
    wr(3'd0, 16'h0002);
    rd(3'd3, 16'h0000, "t2_underrun_clr");
    rd(3'd4, 16'h0000, "t2_late_zero");
    rd(3'd2, 16'h4000, "t2_status_drained");
    chk("t2_all_drained", exp0_q.size(), 32'd0);

    // Ch1 stalled for several ticks: LATE counts them, no pops happen.
    bus.srcRdy1 = 1'b0;
    push_pair(14'h01A5, 14'h00C3, 1'b1);
    push_pair(14'h02B4, 14'h03D2, 1'b1);
    n0_base = n0;
    w = cyc_cnt;
    wr(3'd0, 16'h0001);
    wait_until(w + 8);
    chk("t3_ch1_valid_held", {31'd0, bus.srcValid1}, 32'd1);
    chk("t3_ch1_data_stable", {18'd0, bus.srcData1}, 32'h01A5);
    chk("t3_ch0_once", n0 - n0_base, 32'd1);
    rd(3'd2, 16'h0001, "t3_no_pop");
    wait_until(w + 13);
    bus.srcRdy1 = 1'b1;
    wait_until(w + 15);
    wr(3'd0, 16'h0000);
    rd(3'd4, 16'h0005, "t3_late5");
    rd(3'd3, 16'h0000, "t3_underrun0");
    chk("t3_ch0_total", n0 - n0_base, 32'd2);
    chk("t3_drained", exp1_q.size(), 32'd0);

    // UNDERRUN saturation and CLR self-clearing.
    wr(3'd1, 16'd0);
    wr(3'd0, 16'h0003);
    repeat (65540) step();
    rd(3'd3, 16'hFFFF, "t4_underrun_sat");
    rd(3'd3, 16'hFFFF, "t4_underrun_sat_again");
    rd(3'd4, 16'h0000, "t4_late0");
    wr(3'd0, 16'h0003);
    rd(3'd3, 16'h0000, "t4_underrun_clr");
    rd(3'd0, 16'h0001, "t4_ctrl_en_kept");
    wr(3'd0, 16'h0000);
`else
    // Hold-last: empty tick re-sends the last popped pair.
    wr(3'd1, 16'd3);
    push_pair(14'h0155, 14'h02AA, 1'b1);
    exp0_q.push_back(14'h02AA);
    exp1_q.push_back(14'h0155);
    t0_q.delete();
    w = cyc_cnt;
    wr(3'd0, 16'h0001);
    wait_until(w + 9);
    wr(3'd0, 16'h0000);
    rd(3'd3, 16'h0001, "h_underrun1");
    rd(3'd4, 16'h0000, "h_late0");
    chk("h_xfer_count", t0_q.size(), 32'd2);
    if (t0_q.size() == 2) begin
      chk("h_first_cycle", t0_q[0], w + 5);
      chk("h_resend_cycle", t0_q[1], w + 9);
    end
    chk("h_resent", exp0_q.size(), 32'd0);
`endif

    // Reset in the middle of a pending transfer.
    bus.srcRdy0 = 1'b0;
    bus.srcRdy1 = 1'b0;
    wr(3'd1, 16'd5);
    push_pair(14'h00AB, 14'h01CD, 1'b0);
    push_pair(14'h00AC, 14'h01CE, 1'b0);
    w = cyc_cnt;
    wr(3'd0, 16'h0001);
    wait_until(w + 9);
    chk("r_valid_before", {31'd0, bus.srcValid0}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("r_srcValid0", {31'd0, bus.srcValid0}, 32'd0);
    chk("r_srcValid1", {31'd0, bus.srcValid1}, 32'd0);
    chk("r_snkRdy",    {31'd0, bus.snkRdy},    32'd1);
    rd(3'd2, 16'h4000, "r_status");
    rd(3'd1, 16'(RATE_RST), "r_rate");
    rd(3'd0, 16'h0000, "r_ctrl");
    bus.srcRdy0 = 1'b1;
    bus.srcRdy1 = 1'b1;
    repeat (4) step();
    chk("r_no_stray_output", {31'd0, bus.srcValid0}, 32'd0);
    chk("end_reads_done", rd_q.size(), 32'd0);
    chk("end_stream_done", exp0_q.size() + exp1_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
